// File: rtl/pipe_sequencer.sv
// Game-flow controller: owns the idle/load/run/over state machine,
// scrolls both pipes per frame tick, fetches gap heights and keeps score.
module pipe_sequencer #(
    parameter int SCREEN_W     = 640,
    parameter int PIPE_SPACING = 320,
    parameter int SPEED        = 2,
    parameter int BIRD_X       = 200
) (
    input  logic        Clks,
    input  logic        Reset,
    input  logic        Button,
    input  logic        Tick,
    input  logic        Collision,
    input  logic [15:0] GapIn,
    input  logic        GapValid,
    output logic        GapReq,
    output logic        GapSel,
    output logic [15:0] PipesPosition1,
    output logic [15:0] PipesPosition2,
    output logic [15:0] Gap1,
    output logic [15:0] Gap2,
    output logic [15:0] Score,
    output logic [1:0]  State,
    output logic        Running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [15:0] WRAP    = 16'(2 * PIPE_SPACING);
    localparam logic [15:0] STEP    = 16'(SPEED);
    localparam logic [15:0] P1_INIT = 16'(SCREEN_W);
    localparam logic [15:0] P2_INIT = 16'(SCREEN_W + PIPE_SPACING);
    localparam logic [15:0] BX      = 16'(BIRD_X);

    state_t      state, state_n;
    logic [15:0] pos1_n, pos2_n, gap1_n, gap2_n, score_n;
    logic        req_n, sel_n;
    logic        pend1, pend2, pend1_n, pend2_n;
    logic        button_q, press;
    logic [1:0]  hits;
    logic [16:0] score_sum;

    assign press = !Button && button_q;
    assign State = state;

    // Next-state, request engine, scrolling and scoring
    always_comb begin
        state_n   = state;
        pos1_n    = PipesPosition1;
        pos2_n    = PipesPosition2;
        gap1_n    = Gap1;
        gap2_n    = Gap2;
        score_n   = Score;
        req_n     = GapReq;
        sel_n     = GapSel;
        pend1_n   = pend1;
        pend2_n   = pend2;
        hits      = 2'd0;
        score_sum = {1'b0, Score};
        unique case (state)
            IDLE: begin
                if (press) begin
                    state_n = LOAD;
                    pend1_n = 1'b1;
                    pend2_n = 1'b1;
                end
            end
            LOAD, RUN: begin
                if (state == RUN && Collision) begin
                    state_n = OVER;
                    req_n   = 1'b0;
                    pend1_n = 1'b0;
                    pend2_n = 1'b0;
                end else begin
                    if (GapReq) begin
                        if (GapValid) begin
                            req_n = 1'b0;
                            if (GapSel) begin
                                gap2_n  = GapIn;
                                pend2_n = 1'b0;
                            end else begin
                                gap1_n  = GapIn;
                                pend1_n = 1'b0;
                            end
                        end
                    end else if (pend1 || pend2) begin
                        req_n = 1'b1;
                        sel_n = !pend1;
                    end
                    if (state == LOAD) begin
                        if (!pend1 && !pend2 && !GapReq) begin
                            state_n = RUN;
                        end
                    end else if (Tick) begin
                        // a wrap re-arms the fetch even if the same
                        // pipe's previous request is completing now
                        if (PipesPosition1 == 16'd0) begin
                            pos1_n  = WRAP;
                            pend1_n = 1'b1;
                        end else begin
                            pos1_n = PipesPosition1 - STEP;
                        end
                        if (PipesPosition2 == 16'd0) begin
                            pos2_n  = WRAP;
                            pend2_n = 1'b1;
                        end else begin
                            pos2_n = PipesPosition2 - STEP;
                        end
                        hits = {1'b0, PipesPosition1 == BX}
                             + {1'b0, PipesPosition2 == BX};
                    end
                end
            end
            OVER: begin
                if (press) begin
                    state_n = IDLE;
                    pos1_n  = P1_INIT;
                    pos2_n  = P2_INIT;
                    gap1_n  = 16'd0;
                    gap2_n  = 16'd0;
                    score_n = 16'd0;
                    pend1_n = 1'b0;
                    pend2_n = 1'b0;
                end
            end
        endcase
        if (hits != 2'd0) begin
            score_sum = {1'b0, Score} + {15'd0, hits};
            score_n   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    // Register all state and outputs; synchronous active-low reset
    always_ff @(posedge Clks) begin
        if (!Reset) begin
            state          <= IDLE;
            PipesPosition1 <= P1_INIT;
            PipesPosition2 <= P2_INIT;
            Gap1           <= 16'd0;
            Gap2           <= 16'd0;
            Score          <= 16'd0;
            GapReq         <= 1'b0;
            GapSel         <= 1'b0;
            pend1          <= 1'b0;
            pend2          <= 1'b0;
            button_q       <= 1'b1;
            Running        <= 1'b0;
        end else begin
            state          <= state_n;
            PipesPosition1 <= pos1_n;
            PipesPosition2 <= pos2_n;
            Gap1           <= gap1_n;
            Gap2           <= gap2_n;
            Score          <= score_n;
            GapReq         <= req_n;
            GapSel         <= sel_n;
            pend1          <= pend1_n;
            pend2          <= pend2_n;
            button_q       <= Button;
            Running        <= (state_n == RUN);
        end
    end

endmodule
